mem_lsu: RTL and testbench

Load/store sequencer for the OTTER multicycle CPU, placed directly upstream of the `memory` block. It accepts one load or store request at a time from the control FSM over a valid/ready handshake. It drives the memory port for that single access, waits out the block RAM's one-cycle read latency, and returns registered read data plus an error flag over a valid/ready response channel. A faulting access never writes memory.

---
 rtl/mem_lsu.sv | 103 ++++++++++
 tb/tb_mem_lsu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store sequencer in front of the OTTER block-RAM memory: one access per request,
// waits out the one-cycle read latency and returns registered data/error over valid/ready.
module mem_lsu #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [BUS_WIDTH-1:0] req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   input  logic [1:0]           req_size,
   input  logic                 req_sign,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [BUS_WIDTH-1:0] resp_rdata,
   output logic                 resp_error,
   output logic                 mem_we,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_data,
   output logic [1:0]           mem_size,
   output logic                 mem_sign,
   input  logic [BUS_WIDTH-1:0] mem_out,
   input  logic                 mem_error
);

   typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

   // The memory's word address must fit inside the byte-address bus.
   if (ADDR_WIDTH > BUS_WIDTH) begin : g_addr_wider_than_bus
   end

   state_t               state_q;
   logic                 we_q;
   logic                 sign_q;
   logic [1:0]           size_q;
   logic [BUS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0] wdata_q;
   logic [BUS_WIDTH-1:0] rdata_q;
   logic                 err_q;
   logic                 fault;

   assign fault = mem_error || (size_q == 2'b11);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  sign_q  <= req_sign;
                  size_q  <= req_size;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (fault || we_q) begin
                  err_q   <= fault;
                  rdata_q <= '0;
                  state_q <= DONE;
               end else begin
                  state_q <= READ;
               end
            end
            READ: begin
               rdata_q <= mem_out;
               err_q   <= 1'b0;
               state_q <= DONE;
            end
            DONE: begin
               if (resp_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == DONE);
   assign resp_rdata = rdata_q;
   assign resp_error = err_q;

   // Gated by rst_n so a store caught by reset in ACCESS never reaches the RAM.
   assign mem_we   = rst_n && (state_q == ACCESS) && we_q && !fault;
   assign mem_addr = addr_q;
   assign mem_data = wdata_q;
   assign mem_size = size_q;
   assign mem_sign = sign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a byte-array RAM stand-in feeds the DUT, a reference byte array
// predicts load data, and a negedge process compares every output each cycle.
module tb_mem_lsu;
   logic        clk = 1'b0;
   logic        rst_n, req_valid, req_ready, req_we, req_sign;
   logic        resp_valid, resp_ready, resp_error, mem_we, mem_sign, mem_error;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_data, mem_out;
   logic [1:0]  req_size, mem_size;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_size(mem_size), .mem_sign(mem_sign),
      .mem_out(mem_out), .mem_error(mem_error)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Little-endian byte lanes; sign bit 0 means sign-extend.
   function automatic logic [31:0] splice(input logic [7:0] b0, b1, b2, b3,
                                          input logic [1:0] sz, input logic sg);
      case (sz)
         2'b00:   return sg ? {24'h0, b0} : {{24{b0[7]}}, b0};
         2'b01:   return sg ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   function automatic logic misfit(input logic [31:0] a, input logic [1:0] sz);
      return (a >= 32'd256) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   // RAM stand-in: combinational error, registered read, write on mem_we.
   logic [7:0] ram [256];
   assign mem_error = misfit(mem_addr, mem_size);
   always @(posedge clk) begin
      mem_out <= splice(ram[mem_addr[7:0]], ram[mem_addr[7:0] + 8'd1],
                        ram[mem_addr[7:0] + 8'd2], ram[mem_addr[7:0] + 8'd3], mem_size, mem_sign);
      if (mem_we) begin
         ram[mem_addr[7:0]] <= mem_data[7:0];
         if (mem_size != 2'b00) ram[mem_addr[7:0] + 8'd1] <= mem_data[15:8];
         if (mem_size == 2'b10) begin
            ram[mem_addr[7:0] + 8'd2] <= mem_data[23:16];
            ram[mem_addr[7:0] + 8'd3] <= mem_data[31:24];
         end
      end
   end

   // Reference model state and per-cycle expectations.
   logic [7:0]  ref_mem [256];
   logic        chk_en = 1'b0;
   logic        e_rr, e_rv, e_we, e_resp, e_err, m_sign;
   logic [31:0] e_rdata, m_addr, m_data;
   logic [1:0]  m_size;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(e_rr));
         chk("resp_valid", 32'(resp_valid), 32'(e_rv));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_data", mem_data, m_data);
         chk("mem_size", 32'(mem_size), 32'(m_size));
         chk("mem_sign", 32'(mem_sign), 32'(m_sign));
         if (e_resp) begin
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("resp_error", 32'(resp_error), 32'(e_err));
         end
      end
   end

   task automatic set_reset_exp();
      e_rr = 1'b1; e_rv = 1'b0; e_we = 1'b0; e_resp = 1'b1; e_rdata = '0; e_err = 1'b0;
      m_addr = '0; m_data = '0; m_size = 2'b00; m_sign = 1'b0;
   endtask

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      ref_mem[a[7:0]] = d[7:0];
      if (sz != 2'b00) ref_mem[a[7:0] + 8'd1] = d[15:8];
      if (sz == 2'b10) begin
         ref_mem[a[7:0] + 8'd2] = d[23:16];
         ref_mem[a[7:0] + 8'd3] = d[31:24];
      end
   endtask

   // One request from handshake to response; hold = DONE cycles with resp_ready low.
   task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input int hold,
                       output logic [31:0] got_d, output logic got_e);
      logic        flt;
      logic [31:0] exp_d;
      flt   = misfit(a, sz) || (sz == 2'b11);
      exp_d = (flt || we) ? 32'h0 :
              splice(ref_mem[a[7:0]], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0] + 8'd2],
                     ref_mem[a[7:0] + 8'd3], sz, sg);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_sign = sg;
      resp_ready = 1'b1;
      e_rr = 1'b1; e_rv = 1'b0; e_we = 1'b0; e_resp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_we = 1'b1;
      m_addr = a; m_data = wd; m_size = sz; m_sign = sg;
      e_rr = 1'b0; e_we = we && !flt;
      if (we && !flt) ref_store(a, wd, sz);
      if (!flt && !we) begin
         @(posedge clk); #1;
         e_we = 1'b0;
      end
      @(posedge clk); #1;
      e_we = 1'b0; e_rv = 1'b1; e_resp = 1'b1; e_rdata = exp_d; e_err = flt;
      got_d = resp_rdata; got_e = resp_error;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         resp_ready = (i == hold);
         req_valid  = (i < hold);
         req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h5555_5555; req_size = 2'b10;
      end
   endtask

   logic [31:0] d;
   logic        e;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b00; req_sign = 1'b0; resp_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
      ram[8'h10] = 8'hEF; ram[8'h11] = 8'hBE; ram[8'h12] = 8'hAD; ram[8'h13] = 8'hDE;
      ram[8'h20] = 8'h04; ram[8'h21] = 8'h03; ram[8'h22] = 8'h02; ram[8'h23] = 8'h01;
      ram[8'h30] = 8'h44; ram[8'h31] = 8'h33; ram[8'h32] = 8'h22; ram[8'h33] = 8'h11;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

      @(posedge clk); #1;
      set_reset_exp();
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, d, e);
      chk("lit_load_word", d, 32'hDEAD_BEEF);
      xact(1'b1, 32'h21, 32'h0000_00A5, 2'b00, 1'b0, 0, d, e);
      xact(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 0, d, e);
      chk("lit_load_sbyte", d, 32'hFFFF_FFA5);
      xact(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 0, d, e);
      chk("lit_load_ubyte", d, 32'h0000_00A5);
      xact(1'b1, 32'h22, 32'hCAFE_F00D, 2'b10, 1'b0, 0, d, e);
      chk("lit_misaligned_err", 32'(e), 32'h1);
      xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, d, e);
      chk("lit_readback", d, 32'h0102_A504);
      xact(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 0, d, e);
      chk("lit_illegal_err", 32'(e), 32'h1);
      xact(1'b1, 32'h40, 32'h1234_BEEF, 2'b01, 1'b0, 0, d, e);
      xact(1'b0, 32'h40, 32'h0, 2'b01, 1'b0, 0, d, e);
      chk("lit_load_shalf", d, 32'hFFFF_BEEF);
      xact(1'b0, 32'h41, 32'h0, 2'b01, 1'b1, 0, d, e);
      chk("lit_mis_half_err", 32'(e), 32'h1);
      xact(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, d, e);
      chk("lit_range_err", 32'(e), 32'h1);
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, d, e);
      chk("lit_backpressure", d, 32'hDEAD_BEEF);

      // Reset lands while the store to 0x30 sits in ACCESS.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hA5A5_A5A5;
      req_size = 2'b10; req_sign = 1'b0; resp_ready = 1'b1;
      e_rr = 1'b1; e_rv = 1'b0; e_we = 1'b0; e_resp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; rst_n = 1'b0;
      m_addr = 32'h30; m_data = 32'hA5A5_A5A5; m_size = 2'b10; m_sign = 1'b0;
      e_rr = 1'b0; e_we = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_reset_exp();
      xact(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 0, d, e);
      chk("lit_reset_no_write", d, 32'h1122_3344);

      @(posedge clk); #1;
      e_rr = 1'b1; e_rv = 1'b0; e_we = 1'b0; e_resp = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
